// File: rtl/lcd_bus_responder_if.sv
// rtl/lcd_bus_responder_if.sv - HD44780-style character-LCD bus bundle
interface lcd_bus_responder_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic [7:0] rd_data;
  logic       rd_oe;

  modport master (output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, input rd_data, rd_oe);
  modport slave  (input LCD_DATA, LCD_RS, LCD_RW, LCD_EN, output rd_data, rd_oe);
endinterface

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - LCD bus device end with 2x16 DDRAM image, AC and busy flag
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  lcd_bus_responder_if.slave bus,
  input  logic [4:0] char_addr,
  output logic [7:0] char_data,
  output logic [4:0] cursor,
  output logic       busy,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic       err_busy,
  output logic       err_addr
);

  localparam int MAXC = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] SWEEP_TAIL = CW'((CLEAR_CYCLES > 32) ? CLEAR_CYCLES - 33 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_BUSY} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [4:0]      sweep_idx, sweep_n;
  logic [4:0]      ac, ac_n, ac_step;
  logic            id, id_n, cg, cg_n;
  logic            strobe_n, eb_n, ea_n;
  logic [7:0]      cmd_n;
  logic            img_we;
  logic [4:0]      img_waddr;
  logic [7:0]      img_wdata;
  logic [7:0]      img [32];
  logic [7:0]      rd_next;
  logic [6:0]      ddaddr;

  logic en_s1, en_s2, en_s3, rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0] d_s1, d_s2;
  logic fe;

  assign fe      = en_s3 & ~en_s2;
  assign busy    = (state != S_IDLE);
  assign cursor  = ac;
  assign ac_step = id ? ac + 5'd1 : ac - 5'd1;
  assign ddaddr  = {ac[4], 2'b00, ac[3:0]};

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sweep_n   = sweep_idx;
    ac_n      = ac;
    id_n      = id;
    cg_n      = cg;
    img_we    = 1'b0;
    img_waddr = ac;
    img_wdata = d_s2;
    strobe_n  = 1'b0;
    cmd_n     = cmd_byte;
    eb_n      = 1'b0;
    ea_n      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fe && !rw_s2 && !rs_s2) begin
          strobe_n = 1'b1;
          cmd_n    = d_s2;
          state_n  = S_BUSY;
          cnt_n    = BUSY_LOAD;
          if (d_s2 == 8'h01) begin
            ac_n    = '0;
            id_n    = 1'b1;
            sweep_n = '0;
            state_n = S_SWEEP;
          end else if (d_s2[7:1] == 7'h01) begin
            ac_n  = '0;
            cnt_n = CLEAR_LOAD;
          end else if (d_s2[7:2] == 6'h01) begin
            id_n = d_s2[1];
          end else if (d_s2[7:4] == 4'h1) begin
            if (!d_s2[3]) ac_n = d_s2[2] ? ac + 5'd1 : ac - 5'd1;
          end else if (d_s2[7:6] == 2'b01) begin
            cg_n = 1'b1;
          end else if (d_s2[7]) begin
            // Only line-1 (0x00-0x0F) and line-2 (0x40-0x4F) DDRAM addresses exist
            if (d_s2[6:4] == 3'b000 || d_s2[6:4] == 3'b100) begin
              ac_n = {d_s2[6], d_s2[3:0]};
              cg_n = 1'b0;
            end else begin
              strobe_n = 1'b0;
              cmd_n    = cmd_byte;
              ea_n     = 1'b1;
            end
          end
        end else if (fe && rs_s2) begin
          state_n = S_BUSY;
          cnt_n   = BUSY_LOAD;
          if (!cg) begin
            ac_n   = ac_step;
            img_we = ~rw_s2;
          end
        end
      end
      S_SWEEP: begin
        img_we    = 1'b1;
        img_waddr = sweep_idx;
        img_wdata = 8'h20;
        sweep_n   = sweep_idx + 5'd1;
        eb_n      = fe & ~rw_s2;
        if (sweep_idx == 5'd31) begin
          state_n = (CLEAR_CYCLES > 32) ? S_BUSY : S_IDLE;
          cnt_n   = SWEEP_TAIL;
        end
      end
      S_BUSY: begin
        eb_n = fe & ~rw_s2;
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rd_next = 8'h00;
    if (en_s2 && rw_s2) begin
      if (!rs_s2)                          rd_next = {busy, ddaddr};
      else if (state == S_IDLE && !cg)     rd_next = img[ac];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {en_s1, en_s2, en_s3, rs_s1, rs_s2, rw_s1, rw_s2} <= '0;
      d_s1       <= '0;
      d_s2       <= '0;
      state      <= S_IDLE;
      cnt        <= '0;
      sweep_idx  <= '0;
      ac         <= '0;
      id         <= 1'b1;
      cg         <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_byte   <= '0;
      err_busy   <= 1'b0;
      err_addr   <= 1'b0;
      char_data  <= '0;
      bus.rd_oe  <= 1'b0;
      bus.rd_data <= '0;
      for (int i = 0; i < 32; i++) img[i] <= 8'h20;
    end else begin
      en_s1 <= bus.LCD_EN;  en_s2 <= en_s1;  en_s3 <= en_s2;
      rs_s1 <= bus.LCD_RS;  rs_s2 <= rs_s1;
      rw_s1 <= bus.LCD_RW;  rw_s2 <= rw_s1;
      d_s1  <= bus.LCD_DATA; d_s2 <= d_s1;
      state      <= state_n;
      cnt        <= cnt_n;
      sweep_idx  <= sweep_n;
      ac         <= ac_n;
      id         <= id_n;
      cg         <= cg_n;
      cmd_strobe <= strobe_n;
      cmd_byte   <= cmd_n;
      err_busy   <= eb_n;
      err_addr   <= ea_n;
      char_data  <= img[char_addr];
      bus.rd_oe  <= en_s2 & rw_s2;
      bus.rd_data <= rd_next;
      if (img_we) img[img_waddr] <= img_wdata;
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb/tb_lcd_bus_responder.sv - scoreboard bench for lcd_bus_responder with a behavioural LCD model
module tb_lcd_bus_responder;
  localparam int BUSY_N  = 40;
  localparam int CLEAR_N = 100;
  localparam int EV_CMD = 0, EV_BUSY = 1, EV_ADDR = 2;

  typedef struct {
    int         kind;
    logic [7:0] cmd;
    logic [4:0] cur;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] char_addr = '0;
  logic [7:0] char_data, cmd_byte;
  logic [4:0] cursor;
  logic       busy, cmd_strobe, err_busy, err_addr;

  lcd_bus_responder_if bif ();

  lcd_bus_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clk(clk), .rst(rst), .bus(bif), .char_addr(char_addr), .char_data(char_data),
    .cursor(cursor), .busy(busy), .cmd_strobe(cmd_strobe), .cmd_byte(cmd_byte),
    .err_busy(err_busy), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  ev_t ev_q[$];
  logic [7:0] rd_q[$];
  int busy_q[$];
  bit abort = 1'b0;

  // Reference model of the LCD's visible state
  logic [7:0] m_img [32];
  int         m_ac;
  bit         m_id, m_cg;
  logic [7:0] m_cmd;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_img[i] = 8'h20;
    m_ac = 0; m_id = 1'b1; m_cg = 1'b0; m_cmd = 8'h00;
  endtask

  function automatic int step_ac(input int a, input bit up);
    return up ? (a + 1) % 32 : (a + 31) % 32;
  endfunction

  task automatic bus_cycle(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge clk);
    bif.LCD_RS = rs; bif.LCD_RW = rw; bif.LCD_DATA = d;
    @(negedge clk);
    bif.LCD_EN = 1'b1;
    repeat (5) @(negedge clk);
    bif.LCD_EN = 1'b0;
    repeat (4) @(negedge clk);
    bif.LCD_RS = 1'b0; bif.LCD_RW = 1'b0; bif.LCD_DATA = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) cmp("wait_idle_timeout", 1, 0);
  endtask

  task automatic do_cmd(input logic [7:0] c, input bit while_busy);
    ev_t e;
    int  len = BUSY_N;
    e.kind = EV_CMD;
    if (while_busy) begin
      e.kind = EV_BUSY;
    end else begin
      if (c == 8'h01) begin
        for (int i = 0; i < 32; i++) m_img[i] = 8'h20;
        m_ac = 0; m_id = 1'b1; len = CLEAR_N;
      end else if (c == 8'h02 || c == 8'h03) begin
        m_ac = 0; len = CLEAR_N;
      end else if (c >= 8'h04 && c <= 8'h07) begin
        m_id = c[1];
      end else if (c >= 8'h10 && c <= 8'h1F) begin
        if (c < 8'h18) m_ac = step_ac(m_ac, c[2]);
      end else if (c >= 8'h40 && c <= 8'h7F) begin
        m_cg = 1'b1;
      end else if (c >= 8'h80 && c <= 8'h8F) begin
        m_ac = c - 8'h80; m_cg = 1'b0;
      end else if (c >= 8'hC0 && c <= 8'hCF) begin
        m_ac = 16 + (c - 8'hC0); m_cg = 1'b0;
      end else if (c >= 8'h80) begin
        e.kind = EV_ADDR;
      end
      if (e.kind == EV_CMD) m_cmd = c;
      busy_q.push_back(len);
    end
    e.cmd = m_cmd;
    e.cur = 5'(m_ac);
    ev_q.push_back(e);
    bus_cycle(1'b0, 1'b0, c);
  endtask

  task automatic do_write(input logic [7:0] d, input bit while_busy);
    ev_t e;
    if (while_busy) begin
      e.kind = EV_BUSY; e.cmd = m_cmd; e.cur = 5'(m_ac);
      ev_q.push_back(e);
    end else begin
      if (!m_cg) begin
        m_img[m_ac] = d;
        m_ac = step_ac(m_ac, m_id);
      end
      busy_q.push_back(BUSY_N);
    end
    bus_cycle(1'b1, 1'b0, d);
  endtask

  task automatic do_read();
    rd_q.push_back(m_img[m_ac]);
    m_ac = step_ac(m_ac, m_id);
    busy_q.push_back(BUSY_N);
    bus_cycle(1'b1, 1'b1, 8'h00);
  endtask

  task automatic do_status(input bit while_busy);
    logic [7:0] s;
    s = (m_ac < 16) ? 8'(m_ac) : 8'(8'h40 + m_ac - 16);
    if (while_busy) s = s | 8'h80;
    rd_q.push_back(s);
    bus_cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic check_state();
    @(negedge clk);
    char_addr = 5'd0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      cmp($sformatf("image[%0d]", i), char_data, m_img[i]);
      char_addr = 5'(i + 1);
    end
    cmp("cursor", cursor, m_ac);
  endtask

  // Monitor: pulse outputs
  always @(negedge clk) begin
    if (!rst && (cmd_strobe || err_busy || err_addr)) begin
      int  k;
      ev_t e;
      k = (int'(cmd_strobe) + int'(err_busy) + int'(err_addr) > 1) ? 3 :
          cmd_strobe ? EV_CMD : (err_busy ? EV_BUSY : EV_ADDR);
      if (ev_q.size() == 0) begin
        cmp("unexpected_pulse", k, -1);
      end else begin
        e = ev_q.pop_front();
        cmp("pulse_kind", k, e.kind);
        cmp("cmd_byte", cmd_byte, e.cmd);
        cmp("pulse_cursor", cursor, e.cur);
      end
    end
  end

  // Monitor: read cycles
  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (bif.rd_oe && !prev_oe) begin
      if (rd_q.size() == 0) cmp("unexpected_read", bif.rd_data, -1);
      else                  cmp("rd_data", bif.rd_data, rd_q.pop_front());
    end
    if (!bif.rd_oe && prev_oe) cmp("rd_data_released", bif.rd_data, 0);
    prev_oe = bif.rd_oe;
  end

  // Monitor: busy duration
  int run = 0;
  always @(negedge clk) begin
    if (busy) begin
      run++;
    end else if (run > 0) begin
      if (abort) abort = 1'b0;
      else if (busy_q.size() == 0) cmp("unexpected_busy", run, 0);
      else cmp("busy_length", run, busy_q.pop_front());
      run = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int r;
    bif.LCD_EN = 1'b0; bif.LCD_RS = 1'b0; bif.LCD_RW = 1'b0; bif.LCD_DATA = 8'h00;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("reset_busy", busy, 0);
    cmp("reset_rd_oe", bif.rd_oe, 0);
    cmp("reset_cmd_byte", cmd_byte, 0);
    check_state();

    do_cmd(8'hC5, 0); wait_idle();
    do_write(8'h41, 0); wait_idle();
    do_write(8'h42, 0); wait_idle();
    check_state();

    do_cmd(8'h80, 0); wait_idle();
    do_cmd(8'h04, 0); wait_idle();
    do_write(8'h5A, 0); wait_idle();
    check_state();
    do_cmd(8'h8F, 0); wait_idle();
    do_cmd(8'h06, 0); wait_idle();
    do_write(8'h31, 0); wait_idle();
    check_state();

    do_cmd(8'h80, 0); wait_idle();
    for (int i = 0; i < 32; i++) begin
      do_write(8'($urandom_range(33, 126)), 0); wait_idle();
    end
    check_state();
    do_cmd(8'h01, 0);
    do_write(8'h55, 1);
    do_status(1);
    wait_idle();
    check_state();

    do_cmd(8'hC2, 0); wait_idle();
    do_status(0);
    do_cmd(8'h90, 0); wait_idle();
    do_cmd(8'h40, 0); wait_idle();
    do_write(8'h77, 0); wait_idle();
    check_state();
    do_cmd(8'h80, 0); wait_idle();

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: begin
          case ($urandom_range(0, 7))
            0: c = 8'h01;
            1: c = 8'h02;
            2: c = 8'h04 | 8'($urandom_range(0, 3));
            3: c = 8'h10 | 8'($urandom_range(0, 15));
            4: c = 8'h80 | 8'($urandom_range(0, 15));
            5: c = 8'hC0 | 8'($urandom_range(0, 15));
            6: c = 8'h40 | 8'($urandom_range(0, 63));
            default: c = 8'h90 | 8'($urandom_range(0, 15));
          endcase
          do_cmd(c, 0);
        end
        1, 2: do_cmd(8'($urandom_range(0, 255)), 0);
        3, 4, 5: do_write(8'($urandom), 0);
        6: if (!m_cg) do_read(); else do_write(8'($urandom), 0);
        7: do_status(0);
        default: begin
          do_write(8'($urandom), 0);
          if ($urandom_range(0, 1) == 0) do_write(8'($urandom), 1);
          else                           do_cmd(8'($urandom_range(0, 255)), 1);
        end
      endcase
      wait_idle();
      if (n % 8 == 7) check_state();
    end
    check_state();

    do_cmd(8'h01, 0);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    busy_q.delete();
    rst = 1'b1;
    @(negedge clk);
    cmp("reset_abort_busy", busy, 0);
    rst = 1'b0;
    model_reset();
    check_state();

    repeat (5) @(negedge clk);
    cmp("ev_q_drained", ev_q.size(), 0);
    cmp("rd_q_drained", rd_q.size(), 0);
    cmp("busy_q_drained", busy_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
